// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the FSM encoding, datapath width and the default halt word.
// No logic; imported by the fetch top level.
package unidade_busca_pkg;

    localparam int LARGURA = 32;

    localparam logic [LARGURA-1:0] PALAVRA_PARADA_PADRAO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        PARADO = 2'd2
    } estado_t;

endpackage

// File: rtl/unidade_busca.sv
// Instruction fetch unit: owns the PC, drives the memory address and hands fetched words to decode.
// Latency: one edge from address to output register; a redirect costs one bubble cycle.
// Backpressure: pronto low freezes the output register and the PC; optional counter under UNIDADE_BUSCA_CONTADOR_EN.
module unidade_busca
    import unidade_busca_pkg::*;
#(
    parameter int                 PROFUNDIDADE   = 32,
    parameter logic [LARGURA-1:0] PC_INICIAL     = '0,
    parameter logic [LARGURA-1:0] PALAVRA_PARADA = PALAVRA_PARADA_PADRAO
) (
    input  logic               clk,
    input  logic               reset,
    output logic [LARGURA-1:0] endEntrada,
    input  logic [LARGURA-1:0] instrucao,
    input  logic               desvio,
    input  logic [LARGURA-1:0] endDesvio,
    input  logic               pronto,
    output logic               valida,
    output logic [LARGURA-1:0] instr_saida,
    output logic [LARGURA-1:0] pc_saida,
    output logic               parado,
    output logic [LARGURA-1:0] contador_instr
);

    localparam int AW = $clog2(PROFUNDIDADE);

    estado_t       estado;
    estado_t       estado_prox;
    logic [AW-1:0] pc;
    logic          carga;
    logic          eh_parada;
    logic          unused_desvio_alto;

    // Redirect wins; a halt word freezes the PC; otherwise increment, wrapping at the memory depth.
    function automatic logic [AW-1:0] pc_seguinte(
        input logic [AW-1:0] atual,
        input logic          desv,
        input logic [AW-1:0] alvo,
        input logic          parar
    );
        if (desv) begin
            return alvo;
        end else if (parar) begin
            return atual;
        end else begin
            return atual + AW'(1);
        end
    endfunction

    assign endEntrada         = {{(LARGURA-AW){1'b0}}, pc};
    assign eh_parada          = (instrucao == PALAVRA_PARADA);
    assign carga              = (estado == BUSCA) && (!valida || pronto) && !desvio;
    assign parado             = (estado == PARADO);
    // Redirect targets are taken modulo the memory depth; the high bits are intentionally dropped.
    assign unused_desvio_alto = ^endDesvio[LARGURA-1:AW];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= INICIO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next state: redirect overrides everything, halt word parks the unit.
    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIO:  estado_prox = BUSCA;
            BUSCA:   if (carga && eh_parada) estado_prox = PARADO;
            PARADO:  estado_prox = PARADO;
            default: estado_prox = INICIO;
        endcase
        if (desvio) begin
            estado_prox = BUSCA;
        end
    end

    // PC and output register: redirect flushes, load refills, handshake without reload drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= PC_INICIAL[AW-1:0];
            valida      <= 1'b0;
            instr_saida <= '0;
            pc_saida    <= '0;
        end else if (desvio) begin
            pc     <= pc_seguinte(pc, 1'b1, endDesvio[AW-1:0], 1'b0);
            valida <= 1'b0;
        end else if (carga) begin
            instr_saida <= instrucao;
            pc_saida    <= endEntrada;
            valida      <= 1'b1;
            pc          <= pc_seguinte(pc, 1'b0, endDesvio[AW-1:0], eh_parada);
        end else if (valida && pronto) begin
            valida <= 1'b0;
        end
    end

`ifdef UNIDADE_BUSCA_CONTADOR_EN
    logic [LARGURA-1:0] contador;

    // Count every accepted handshake, including one coinciding with a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador <= '0;
        end else if (valida && pronto) begin
            contador <= contador + LARGURA'(1);
        end
    end

    assign contador_instr = contador;
`else
    assign contador_instr = '0;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Randomized and directed bench for unidade_busca with a queue-based scoreboard.
// Stimulus drives at posedge+1; the monitor samples and scores at negedge.
// Expected stream: addresses from the last reset/redirect target, stopping after a halt word.
module tb_unidade_busca;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] endEntrada;
    logic [31:0] instrucao;
    logic        desvio;
    logic [31:0] endDesvio;
    logic        pronto;
    logic        valida;
    logic [31:0] instr_saida;
    logic [31:0] pc_saida;
    logic        parado;
    logic [31:0] contador_instr;

    logic [31:0] halt_addr = 32'hFFFF_FFFF;
    item_t       esperado[$];
    int          vetores = 0;
    int          erros   = 0;
    int          hs_count = 0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr, prev_pc, prev_end;

    always #5 clk = ~clk;

    unidade_busca dut (
        .clk            (clk),
        .reset          (reset),
        .endEntrada     (endEntrada),
        .instrucao      (instrucao),
        .desvio         (desvio),
        .endDesvio      (endDesvio),
        .pronto         (pronto),
        .valida         (valida),
        .instr_saida    (instr_saida),
        .pc_saida       (pc_saida),
        .parado         (parado),
        .contador_instr (contador_instr)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == halt_addr) ? 32'hFFFF_FFFF : (32'hA000_0000 | a);
    endfunction

    // Instruction memory model.
    always_comb instrucao = mem(endEntrada);

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] req);
        vetores++;
        if (atual !== req) begin
            erros++;
            $display("FAIL %s: got %h, required %h", nome, atual, req);
        end
    endtask

    // Rebuild the expected delivery stream starting at a word address.
    task automatic carrega_fluxo(input logic [31:0] inicio);
        logic [31:0] a;
        item_t it;
        esperado.delete();
        a = inicio % 32;
        for (int i = 0; i < 400; i++) begin
            it.pc    = a;
            it.instr = mem(a);
            esperado.push_back(it);
            if (it.instr == 32'hFFFF_FFFF) break;
            a = (a + 1) % 32;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic espera_pc(input logic [31:0] alvo);
        bit achou = 0;
        for (int i = 0; i < 100; i++) begin
            if (valida && pc_saida == alvo) begin
                achou = 1;
                break;
            end
            tick();
        end
        vetores++;
        if (!achou) begin
            erros++;
            $display("FAIL wait_pc: got no valid output at pc %h, required within 100 cycles", alvo);
        end
    endtask

    // Monitor: scoreboard pops on handshake, stall stability, counter tracking.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            hs_count   = 0;
        end else begin
            if (prev_stall) begin
                verifica("stall_valida", {31'd0, valida}, 32'd1);
                verifica("stall_instr", instr_saida, prev_instr);
                verifica("stall_pc", pc_saida, prev_pc);
                verifica("stall_end", endEntrada, prev_end);
            end
`ifdef UNIDADE_BUSCA_CONTADOR_EN
            verifica("contador", contador_instr, hs_count);
`else
            verifica("contador_zero", contador_instr, 32'd0);
`endif
            if (valida && pronto) begin
                hs_count++;
                if (esperado.size() == 0) begin
                    vetores++;
                    erros++;
                    $display("FAIL extra_delivery: got pc %h instr %h, required none", pc_saida, instr_saida);
                end else begin
                    item_t it;
                    it = esperado.pop_front();
                    verifica("deliver_pc", pc_saida, it.pc);
                    verifica("deliver_instr", instr_saida, it.instr);
                end
            end
            prev_stall = valida && !pronto && !desvio;
            prev_instr = instr_saida;
            prev_pc    = pc_saida;
            prev_end   = endEntrada;
        end
    end

    task automatic checa_reset();
        verifica("rst_valida", {31'd0, valida}, 32'd0);
        verifica("rst_instr", instr_saida, 32'd0);
        verifica("rst_pc_saida", pc_saida, 32'd0);
        verifica("rst_parado", {31'd0, parado}, 32'd0);
        verifica("rst_contador", contador_instr, 32'd0);
        verifica("rst_end", endEntrada, 32'd0);
    endtask

    task automatic aplica_reset(input logic [31:0] halt);
        reset = 1'b1;
        esperado.delete();
        #1;
        checa_reset();
        halt_addr = halt;
        tick();
        tick();
        reset = 1'b0;
        carrega_fluxo(0);
    endtask

    initial begin
        reset     = 1'b1;
        desvio    = 1'b0;
        endDesvio = '0;
        pronto    = 1'b0;
        tick();
        tick();
        checa_reset();

        // Startup: INICIO cycle, then one word per cycle.
        reset  = 1'b0;
        carrega_fluxo(0);
        pronto = 1'b1;
        tick();
        verifica("inicio_no_load", {31'd0, valida}, 32'd0);
        tick();
        verifica("first_valida", {31'd0, valida}, 32'd1);
        verifica("first_pc", pc_saida, 32'd0);

        // Stall holding word 4.
        espera_pc(32'd4);
        pronto = 1'b0;
        repeat (3) tick();
        verifica("stall_instr4", instr_saida, 32'hA000_0004);
        verifica("stall_end5", endEntrada, 32'd5);
        pronto = 1'b1;
        tick();
        verifica("after_stall", instr_saida, 32'hA000_0005);

        // Wrap-around 31 -> 0.
        espera_pc(32'd31);
        tick();
        verifica("wrap_pc", pc_saida, 32'd0);
        verifica("wrap_instr", instr_saida, 32'hA000_0000);

        // Redirect to 40 (mod 32 = 8) with a valid word pending.
        tick();
        desvio    = 1'b1;
        endDesvio = 32'd40;
        tick();
        desvio = 1'b0;
        carrega_fluxo(32'd40);
        verifica("redir_bubble", {31'd0, valida}, 32'd0);
        verifica("redir_end", endEntrada, 32'd8);
        tick();
        verifica("redir_pc", pc_saida, 32'd8);
        verifica("redir_instr", instr_saida, 32'hA000_0008);

        // Halt word at address 6.
        aplica_reset(32'd6);
        espera_pc(32'd6);
        verifica("halt_instr", instr_saida, 32'hFFFF_FFFF);
        verifica("halt_parado", {31'd0, parado}, 32'd1);
        repeat (5) tick();
        verifica("halt_drained", {31'd0, valida}, 32'd0);
        verifica("halt_pc_hold", endEntrada, 32'd6);
        verifica("halt_all_delivered", esperado.size(), 32'd0);
        desvio    = 1'b1;
        endDesvio = 32'd2;
        tick();
        desvio = 1'b0;
        carrega_fluxo(32'd2);
        verifica("unhalt_parado", {31'd0, parado}, 32'd0);
        tick();
        verifica("unhalt_instr", instr_saida, 32'hA000_0002);

        // Asynchronous reset during a stall, then counter over 10 handshakes.
        aplica_reset(32'hFFFF_FFFF);
        tick();
        tick();
        pronto = 1'b0;
        tick();
        verifica("pre_rst_valida", {31'd0, valida}, 32'd1);
        #2;
        aplica_reset(32'hFFFF_FFFF);
        pronto = 1'b1;
        repeat (12) tick();
`ifdef UNIDADE_BUSCA_CONTADOR_EN
        verifica("count10", contador_instr, 32'd10);
`else
        verifica("count_off", contador_instr, 32'd0);
`endif

        // Random phase with a halt word at 13.
        aplica_reset(32'd13);
        for (int i = 0; i < 800; i++) begin
            pronto    = ($urandom_range(0, 3) != 0);
            desvio    = ($urandom_range(0, 15) == 0);
            endDesvio = $urandom;
            tick();
            if (desvio) begin
                carrega_fluxo(endDesvio);
                desvio = 1'b0;
            end
        end
        pronto = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
